// File: rtl/decode_issue_queue.sv
// Decode-to-issue decoupling FIFO: buffers decoded entries with their control-flow flag and
// presents the head on a valid/ack interface, optionally stalling issue behind an unresolved branch.
module decode_issue_queue #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned ENTRY_W        = 128,
    parameter bit          GATE_CTRL_FLOW = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [ENTRY_W-1:0]       in_instr_i,
    input  logic                     in_valid_i,
    input  logic                     in_is_ctrl_flow_i,
    output logic                     in_ready_o,
    output logic [ENTRY_W-1:0]       decoded_instr_o,
    output logic                     decoded_instr_valid_o,
    output logic                     is_ctrl_flow_o,
    input  logic                     decoded_instr_ack_i,
    input  logic                     resolve_branch_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     branch_pending_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic               ctrl_flow;
        logic [ENTRY_W-1:0] instr;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             branch_pending;
    logic             push;
    logic             pop;

    // Full-queue ready ignores a same-cycle pop: no pop-to-push bypass.
    assign in_ready_o            = (count < CNT_W'(DEPTH));
    assign decoded_instr_valid_o = (count != '0) && !branch_pending;
    assign push                  = in_valid_i && in_ready_o && !flush_i;
    assign pop                   = decoded_instr_valid_o && decoded_instr_ack_i && !flush_i;

    assign head             = mem[rd_ptr];
    assign decoded_instr_o  = head.instr;
    assign is_ctrl_flow_o   = head.ctrl_flow;
    assign count_o          = count;
    assign branch_pending_o = branch_pending;

    // NOTE: the storage array is deliberately reset so the head reads as zero after reset;
    // plain FIFO storage normally stays unreset and relies on count/valid instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {in_is_ctrl_flow_i, in_instr_i};
        end
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    generate
        if (GATE_CTRL_FLOW) begin : g_gate
            // A resolve coincident with popping a new branch retires the older branch only.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    branch_pending <= 1'b0;
                end else if (flush_i) begin
                    branch_pending <= 1'b0;
                end else begin
                    branch_pending <= (branch_pending && !resolve_branch_i) ||
                                      (pop && head.ctrl_flow);
                end
            end
        end else begin : g_no_gate
            assign branch_pending = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_decode_issue_queue.sv
// Randomized and directed bench for decode_issue_queue: a queue-based reference model checks
// every cycle, and a separate monitor scores each issued entry against the stimulus order.
module tb_decode_issue_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ENTRY_W = 128;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

    typedef struct {
        logic               ctrl;
        logic [ENTRY_W-1:0] instr;
    } entry_t;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               flush_i;
    logic [ENTRY_W-1:0] in_instr_i;
    logic               in_valid_i;
    logic               in_is_ctrl_flow_i;
    logic               in_ready_o;
    logic [ENTRY_W-1:0] decoded_instr_o;
    logic               decoded_instr_valid_o;
    logic               is_ctrl_flow_o;
    logic               decoded_instr_ack_i;
    logic               resolve_branch_i;
    logic [CNT_W-1:0]   count_o;
    logic               branch_pending_o;

    decode_issue_queue #(
        .DEPTH          (DEPTH),
        .ENTRY_W        (ENTRY_W),
        .GATE_CTRL_FLOW (1'b1)
    ) dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .in_instr_i            (in_instr_i),
        .in_valid_i            (in_valid_i),
        .in_is_ctrl_flow_i     (in_is_ctrl_flow_i),
        .in_ready_o            (in_ready_o),
        .decoded_instr_o       (decoded_instr_o),
        .decoded_instr_valid_o (decoded_instr_valid_o),
        .is_ctrl_flow_o        (is_ctrl_flow_o),
        .decoded_instr_ack_i   (decoded_instr_ack_i),
        .resolve_branch_i      (resolve_branch_i),
        .count_o               (count_o),
        .branch_pending_o      (branch_pending_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    entry_t model_q[$];
    entry_t exp_q[$];
    bit     model_pending;

    task automatic check(input string name, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},   ENTRY_W'(in_ready_o), 1);
        check({tag, "_valid"},   ENTRY_W'(decoded_instr_valid_o), 0);
        check({tag, "_ctrl"},    ENTRY_W'(is_ctrl_flow_o), 0);
        check({tag, "_count"},   ENTRY_W'(count_o), 0);
        check({tag, "_pending"}, ENTRY_W'(branch_pending_o), 0);
        check({tag, "_instr"},   decoded_instr_o, '0);
    endtask

    // One clock cycle: called #1 after a rising edge, returns #1 after the next one.
    task automatic cycle(input bit v, input bit c, input logic [ENTRY_W-1:0] d,
                         input bit ack, input bit res, input bit fl);
        bit     m_ready, m_valid, m_push, m_pop, head_ctrl;
        entry_t e;
        in_valid_i          = v;
        in_is_ctrl_flow_i   = c;
        in_instr_i          = d;
        decoded_instr_ack_i = ack;
        resolve_branch_i    = res;
        flush_i             = fl;

        m_ready = (model_q.size() < DEPTH);
        m_valid = (model_q.size() != 0) && !model_pending;
        m_push  = v && m_ready && !fl;
        m_pop   = m_valid && ack && !fl;
        head_ctrl = (model_q.size() != 0) ? model_q[0].ctrl : 1'b0;
        e.ctrl  = c;
        e.instr = d;
        if (m_push) exp_q.push_back(e);

        @(negedge clk_i);
        check("count",   ENTRY_W'(count_o), ENTRY_W'(model_q.size()));
        check("ready",   ENTRY_W'(in_ready_o), ENTRY_W'(m_ready));
        check("valid",   ENTRY_W'(decoded_instr_valid_o), ENTRY_W'(m_valid));
        check("pending", ENTRY_W'(branch_pending_o), ENTRY_W'(model_pending));
        if (m_valid) begin
            check("head_instr", decoded_instr_o, model_q[0].instr);
            check("head_ctrl",  ENTRY_W'(is_ctrl_flow_o), ENTRY_W'(model_q[0].ctrl));
        end

        @(posedge clk_i);
        #1;
        if (fl) begin
            model_q.delete();
            exp_q.delete();
            model_pending = 1'b0;
        end else begin
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back(e);
            model_pending = (model_pending && !res) || (m_pop && head_ctrl);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every accepted issue handshake must deliver the oldest outstanding entry.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && decoded_instr_valid_o && decoded_instr_ack_i && !flush_i) begin
                check("sb_nonempty", ENTRY_W'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check("sb_instr", decoded_instr_o, exp_q[0].instr);
                    check("sb_ctrl",  ENTRY_W'(is_ctrl_flow_o), ENTRY_W'(exp_q[0].ctrl));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [ENTRY_W-1:0] a;
        int pushed;
        rst_ni              = 1'b0;
        flush_i             = 1'b0;
        in_instr_i          = '0;
        in_valid_i          = 1'b0;
        in_is_ctrl_flow_i   = 1'b0;
        decoded_instr_ack_i = 1'b0;
        resolve_branch_i    = 1'b0;
        model_pending       = 1'b0;
        #3;
        check_reset_outputs("rst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Single push, single-cycle latency, ack drains.
        a = rnd128();
        cycle(1'b1, 1'b0, a, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        idle();

        // Fill, rejected 5th push, pop+push while full.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, rnd128(), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, rnd128(), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, rnd128(), 1'b1, 1'b0, 1'b0);
        check("full_pop_count", ENTRY_W'(count_o), 3);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Wrap-around with interleaved acks.
        pushed = 0;
        for (int i = 0; i < 20; i++) begin
            bit v;
            v = (pushed < 10);
            if (v && model_q.size() < DEPTH) pushed++;
            cycle(v, 1'b0, rnd128(), (i % 3) != 0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("wrap_pushed", ENTRY_W'(pushed), 10);

        // Branch gate: B (ctrl) then C; C held until resolve.
        cycle(1'b1, 1'b1, rnd128(), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, rnd128(), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("gate_pending", ENTRY_W'(branch_pending_o), 1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Popping a branch in the resolve cycle re-arms the gate.
        cycle(1'b1, 1'b1, rnd128(), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("simul_pending", ENTRY_W'(branch_pending_o), 1);

        // Flush with 3 queued (gated), coincident push and ack.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, rnd128(), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, rnd128(), 1'b1, 1'b0, 1'b1);
        check("flush_count",   ENTRY_W'(count_o), 0);
        check("flush_valid",   ENTRY_W'(decoded_instr_valid_o), 0);
        check("flush_pending", ENTRY_W'(branch_pending_o), 0);
        idle();

        // Asynchronous reset mid-fill.
        cycle(1'b1, 1'b1, rnd128(), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, rnd128(), 1'b1, 1'b0, 1'b0);
        in_valid_i = 1'b0;
        decoded_instr_ack_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("arst");
        model_q.delete();
        exp_q.delete();
        model_pending = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        idle();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(99) < 70, $urandom_range(99) < 25, rnd128(),
                  $urandom_range(99) < 60, $urandom_range(99) < 30, $urandom_range(99) < 3);
        end
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b1, (i % 2) == 0, 1'b0);
        check("sb_drain", ENTRY_W'(exp_q.size()), ENTRY_W'(model_q.size()));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
